// File: rtl/bus_arbiter_q.sv
// -----------------------------------------------------------------------------
// bus_arbiter_q
//
// Purpose:
//   Queued single-owner transfer bus. Per-processor transfer requests are
//   buffered in a bounded circular FIFO of {src, dest} entries. The bus is
//   granted to one queued transfer at a time. A granted transfer holds the bus
//   for TRANSFER_TIME cycles. The cycle after that, request_avail pulses at the
//   destination. The next queued transfer is granted on that same DONE edge,
//   so back-to-back transfers have no idle cycle between them.
//
// Optional feature (macro BUS_ARBITER_RR_EN):
//   defined   - the enqueue scan starts at (last granted src + 1) mod NUM_PROC
//               and wraps. The pointer is 0 after reset.
//   undefined - the enqueue scan always starts at index 0.
//
// Parameters:
//   NUM_PROC      number of requesters / destinations (>= 2)
//   TRANSFER_TIME cycles the bus is held per transfer (>= 1)
//   QUEUE_DEPTH   FIFO entries (>= 1, any value)
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst            asynchronous active-high reset
//   request        per-processor request strobe, sampled every edge
//   request_dest   destination index for each requester
//   request_ack    registered; high the cycle after a request was enqueued
//   request_nack   registered; high the cycle after a request was rejected
//   request_avail  one-cycle pulse at the destination when its transfer ends
//   bus_busy       high while a transfer holds the bus
//   bus_owner      destination of the current or last transfer
//   bus_src        source of the current or last transfer
//   queue_count    registered FIFO occupancy
// -----------------------------------------------------------------------------
module bus_arbiter_q #(
   parameter  int NUM_PROC      = 4,
   parameter  int TRANSFER_TIME = 100,
   parameter  int QUEUE_DEPTH   = 8,
   localparam int ID_W          = $clog2(NUM_PROC),
   localparam int CNT_W         = $clog2(TRANSFER_TIME + 1),
   localparam int Q_W           = $clog2(QUEUE_DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PROC-1:0]            request,
   input  logic [NUM_PROC-1:0][ID_W-1:0]  request_dest,
   output logic [NUM_PROC-1:0]            request_ack,
   output logic [NUM_PROC-1:0]            request_nack,
   output logic [NUM_PROC-1:0]            request_avail,
   output logic                           bus_busy,
   output logic [ID_W-1:0]                bus_owner,
   output logic [ID_W-1:0]                bus_src,
   output logic [Q_W-1:0]                 queue_count
);

   // Pointer width is sized exactly to the storage array, which avoids
   // index-width mismatches. A depth-1 queue still gets a 1-bit pointer.
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int ENT_W = 2 * ID_W;

   // Request handshake:
   //   A requester raises request[i] with request_dest[i] valid in the same
   //   cycle. Every edge resolves each asserted request in full. On the next
   //   cycle, exactly one of request_ack[i] (entry written) or request_nack[i]
   //   (queue full or illegal destination) is high. A nacked request is not
   //   kept anywhere. Holding request high simply asks again on the next edge.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                        state;
   logic [PTR_W-1:0]              head;
   logic [PTR_W-1:0]              tail;
   logic [Q_W-1:0]                count;
   logic [CNT_W-1:0]              countdown;
   logic [ENT_W-1:0]              fifo_mem [QUEUE_DEPTH];

   logic                          pop;
   logic [ID_W-1:0]               pop_src;
   logic [ID_W-1:0]               pop_dest;
   logic [PTR_W-1:0]              head_inc;
   logic [ID_W-1:0]               scan_start;

   logic [NUM_PROC-1:0]           push_en;
   logic [NUM_PROC-1:0]           push_rej;
   logic [NUM_PROC-1:0][PTR_W-1:0] push_slot;
   logic [PTR_W-1:0]              tail_next;
   logic [Q_W-1:0]                count_next;
   logic [NUM_PROC-1:0]           owner_onehot;

   int                            free_slots;
   int                            n_push;
   int                            idx_i;
   int                            slot_i;
   int                            tail_i;
   logic [ID_W-1:0]               idx;

   // A pop can happen only when the bus is free (IDLE or DONE). It always
   // reads the entry at head before the edge, so it never takes an entry
   // that is being pushed on the same edge.
   assign pop      = ((state == S_IDLE) || (state == S_DONE)) && (count != '0);
   assign pop_src  = fifo_mem[head][ENT_W-1:ID_W];
   assign pop_dest = fifo_mem[head][ID_W-1:0];
   assign head_inc = (head == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : head + 1'b1;

   assign queue_count = count;

`ifdef BUS_ARBITER_RR_EN
   logic [ID_W-1:0] rr_ptr;

   // Each pop moves the scan start to just after the source being granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (pop) begin
         rr_ptr <= (pop_src == ID_W'(NUM_PROC - 1)) ? '0 : pop_src + 1'b1;
      end
   end

   assign scan_start = rr_ptr;
`else
   assign scan_start = '0;
`endif

   // Enqueue scan. Free space is measured before this edge's pop, so a
   // slot freed by a pop cannot be reused until the following edge. Requests
   // are written in scan order into consecutive slots after tail.
   always_comb begin
      push_en    = '0;
      push_rej   = '0;
      push_slot  = '0;
      free_slots = QUEUE_DEPTH - int'(count);
      n_push     = 0;
      idx_i      = 0;
      idx        = '0;
      slot_i     = 0;
      tail_i     = 0;
      for (int k = 0; k < NUM_PROC; k++) begin
         idx_i = int'(scan_start) + k;
         if (idx_i >= NUM_PROC) begin
            idx_i = idx_i - NUM_PROC;
         end
         idx = ID_W'(idx_i);
         if (request[idx]) begin
            // An illegal destination is rejected and uses no slot.
            if ((int'(request_dest[idx]) >= NUM_PROC) || (n_push >= free_slots)) begin
               push_rej[idx] = 1'b1;
            end else begin
               push_en[idx] = 1'b1;
               slot_i = int'(tail) + n_push;
               if (slot_i >= QUEUE_DEPTH) begin
                  slot_i = slot_i - QUEUE_DEPTH;
               end
               push_slot[idx] = PTR_W'(slot_i);
               n_push = n_push + 1;
            end
         end
      end
      tail_i = int'(tail) + n_push;
      if (tail_i >= QUEUE_DEPTH) begin
         tail_i = tail_i - QUEUE_DEPTH;
      end
      tail_next  = PTR_W'(tail_i);
      count_next = Q_W'(int'(count) + n_push - (pop ? 1 : 0));
   end

   always_comb begin
      owner_onehot = '0;
      for (int i = 0; i < NUM_PROC; i++) begin
         owner_onehot[i] = (bus_owner == ID_W'(i));
      end
   end

   // FIFO storage. It has no reset: head/tail/count alone decide which
   // entries are valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PROC; i++) begin
         if (push_en[i]) begin
            fifo_mem[push_slot[i]] <= {ID_W'(i), request_dest[i]};
         end
      end
   end

   // Queue pointers, handshake flags and the bus FSM, all with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         countdown     <= '0;
         request_ack   <= '0;
         request_nack  <= '0;
         request_avail <= '0;
         bus_busy      <= 1'b0;
         bus_owner     <= '0;
         bus_src       <= '0;
      end else begin
         tail          <= tail_next;
         count         <= count_next;
         request_ack   <= push_en;
         request_nack  <= push_rej;
         request_avail <= '0;
         if (pop) begin
            head <= head_inc;
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (pop) begin
                  bus_src   <= pop_src;
                  bus_owner <= pop_dest;
                  countdown <= CNT_W'(TRANSFER_TIME - 1);
                  bus_busy  <= 1'b1;
                  state     <= S_XFER;
               end else begin
                  bus_busy  <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            S_XFER: begin
               if (countdown == '0) begin
                  // The pulse is shown in the DONE cycle, which follows the
                  // last XFER cycle.
                  request_avail <= owner_onehot;
                  bus_busy      <= 1'b0;
                  state         <= S_DONE;
               end else begin
                  countdown <= countdown - 1'b1;
               end
            end
            default: begin
               bus_busy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter_q.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_q
//
// Testbench for bus_arbiter_q with NUM_PROC=4, TRANSFER_TIME=4, QUEUE_DEPTH=3.
// A reference model runs alongside the DUT. It keeps the queued transfers in a
// plain queue and derives bus timing from the edge of the most recent grant:
//   - busy during grant..grant+T-1
//   - avail at grant+T
//   - next grant no earlier than grant+T+1
// Every cycle, all outputs are compared with the model. Directed steps add
// fixed expectations for the key scenarios. The run ends with a random phase.
// The bench follows BUS_ARBITER_RR_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_q;

   localparam int NP    = 4;
   localparam int T     = 4;
   localparam int DEPTH = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NP-1:0]     req;
   logic [NP-1:0][1:0] dst;
   logic [NP-1:0]     request_ack;
   logic [NP-1:0]     request_nack;
   logic [NP-1:0]     request_avail;
   logic              bus_busy;
   logic [1:0]        bus_owner;
   logic [1:0]        bus_src;
   logic [1:0]        queue_count;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [3:0]    model_q[$];      // queued {src, dest}
   int            cyc;             // edge number since last reset release
   int            grant_edge;      // edge at which the current/last transfer was granted
   int            next_pop_edge;   // earliest edge at which a new grant may happen
   int            rr_start;
   logic [1:0]    g_src;
   logic [1:0]    g_dst;
   logic [NP-1:0] exp_ack;
   logic [NP-1:0] exp_nack;

   // Clock / reset block.
   always #5 clk = ~clk;

   bus_arbiter_q #(
      .NUM_PROC      (NP),
      .TRANSFER_TIME (T),
      .QUEUE_DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .request       (req),
      .request_dest  (dst),
      .request_ack   (request_ack),
      .request_nack  (request_nack),
      .request_avail (request_avail),
      .bus_busy      (bus_busy),
      .bus_owner     (bus_owner),
      .bus_src       (bus_src),
      .queue_count   (queue_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic model_reset();
      model_q.delete();
      cyc           = 0;
      grant_edge    = -1000;
      next_pop_edge = 0;
      rr_start      = 0;
      g_src         = '0;
      g_dst         = '0;
      exp_ack       = '0;
      exp_nack      = '0;
   endtask

   // Model one rising edge. The inputs seen are the ones driven during the
   // previous cycle.
   task automatic model_edge();
      int         free_n;
      int         n;
      int         idx;
      int         start;
      logic [3:0] ent;
      logic [3:0] new_q[$];
      cyc++;
      exp_ack  = '0;
      exp_nack = '0;
      free_n   = DEPTH - model_q.size();
`ifdef BUS_ARBITER_RR_EN
      start = rr_start;
`else
      start = 0;
`endif
      n = 0;
      for (int k = 0; k < NP; k++) begin
         idx = (start + k) % NP;
         if (req[idx[1:0]]) begin
            if (n < free_n) begin
               new_q.push_back({idx[1:0], dst[idx[1:0]]});
               exp_ack[idx[1:0]] = 1'b1;
               n++;
            end else begin
               exp_nack[idx[1:0]] = 1'b1;
            end
         end
      end
      // The grant takes the oldest entry that was queued before this edge.
      if ((cyc >= next_pop_edge) && (model_q.size() > 0)) begin
         ent           = model_q.pop_front();
         g_src         = ent[3:2];
         g_dst         = ent[1:0];
         grant_edge    = cyc;
         next_pop_edge = cyc + T + 1;
         rr_start      = (int'(g_src) + 1) % NP;
      end
      foreach (new_q[i]) model_q.push_back(new_q[i]);
   endtask

   task automatic check_all();
      logic          ebusy;
      logic [NP-1:0] eav;
      ebusy = (cyc >= grant_edge) && (cyc < grant_edge + T);
      eav   = (cyc == grant_edge + T) ? (4'b0001 << g_dst) : 4'b0000;
      chk("ack",   32'(request_ack),   32'(exp_ack));
      chk("nack",  32'(request_nack),  32'(exp_nack));
      chk("avail", 32'(request_avail), 32'(eav));
      chk("busy",  32'(bus_busy),      32'(ebusy));
      chk("owner", 32'(bus_owner),     32'(g_dst));
      chk("src",   32'(bus_src),       32'(g_src));
      chk("count", 32'(queue_count),   32'(model_q.size()));
   endtask

   // Driver: advance one clock and check every output 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ack"},   32'(request_ack),   32'd0);
      chk({tag, "_nack"},  32'(request_nack),  32'd0);
      chk({tag, "_avail"}, 32'(request_avail), 32'd0);
      chk({tag, "_busy"},  32'(bus_busy),      32'd0);
      chk({tag, "_owner"}, 32'(bus_owner),     32'd0);
      chk({tag, "_src"},   32'(bus_src),       32'd0);
      chk({tag, "_count"}, 32'(queue_count),   32'd0);
   endtask

   // Assert reset in the middle of a cycle. Outputs must clear at once.
   // Release happens just after an edge, so the next edge is the first active one.
   task automatic async_reset();
      req = '0;
      #3 rst = 1'b1;
      #1;
      check_zero("rst_async");
      model_reset();
      @(posedge clk);
      #1;
      check_zero("rst_hold");
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0] s;
      logic [1:0] d;
      req = '0;
      dst = '0;
      model_reset();

      // Reset state.
      @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Single transfer: 2 -> 1.
      req    = 4'b0100;
      dst[2] = 2'd1;
      tick();
      chk("single_ack", 32'(request_ack), 32'h4);
      req = '0;
      repeat (4) tick();
      chk("single_busy_last", 32'(bus_busy), 32'd1);
      tick();
      chk("single_avail", 32'(request_avail), 32'h2);
      chk("single_src", 32'(bus_src), 32'd2);
      tick();
      chk("single_avail_off", 32'(request_avail), 32'h0);
      repeat (2) tick();

      // Back-to-back: 0 -> 3 and 1 -> 2 requested together.
      req    = 4'b0011;
      dst[0] = 2'd3;
      dst[1] = 2'd2;
      tick();
      req = '0;
      repeat (4) tick();
      tick();
      chk("b2b_avail_first", 32'(request_avail), 32'h8);
      chk("b2b_busy_gap1", 32'(bus_busy), 32'd0);
      repeat (4) tick();
      chk("b2b_busy_second", 32'(bus_busy), 32'd1);
      tick();
      chk("b2b_avail_second", 32'(request_avail), 32'h4);
      chk("b2b_busy_gap2", 32'(bus_busy), 32'd0);
      repeat (3) tick();

      // Full FIFO, then a push and a pop on the same edge.
      async_reset();
      req = 4'b1111;
      dst = {2'd0, 2'd1, 2'd2, 2'd3};
      tick();
      chk("full_ack", 32'(request_ack), 32'h7);
      chk("full_nack", 32'(request_nack), 32'h8);
      chk("full_count", 32'(queue_count), 32'd3);
      tick();
      chk("pushpop_nack", 32'(request_nack), 32'hf);
      chk("pushpop_count", 32'(queue_count), 32'd2);
      repeat (18) tick();
      req = '0;
      repeat (20) tick();

      // Reset while a transfer is in progress and two entries are queued.
      req = 4'b0111;
      dst = {2'd0, 2'd3, 2'd2, 2'd1};
      tick();
      req = '0;
      repeat (3) tick();
      chk("midrst_busy", 32'(bus_busy), 32'd1);
      chk("midrst_count", 32'(queue_count), 32'd2);
      async_reset();
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("midrst_no_avail", 32'(request_avail), 32'd0);
      end

      // Wrap-around: seven sequential single transfers through a 3-entry queue.
      for (int i = 0; i < 7; i++) begin
         s      = 2'($urandom_range(0, 3));
         d      = 2'($urandom_range(0, 3));
         req    = 4'b0001 << s;
         dst[s] = d;
         tick();
         req = '0;
         repeat (5) tick();
         chk("wrap_avail", 32'(request_avail), 32'(4'b0001 << d));
         chk("wrap_src", 32'(bus_src), 32'(s));
         chk("wrap_owner", 32'(bus_owner), 32'(d));
         tick();
      end

      // Random traffic, with one reset partway through.
      for (int i = 0; i < 800; i++) begin
         if ((i % 50) < 25) begin
            req = 4'($urandom) & 4'($urandom);
         end else begin
            req = 4'($urandom);
         end
         for (int j = 0; j < NP; j++) begin
            dst[j] = 2'($urandom_range(0, 3));
         end
         if (i == 400) begin
            async_reset();
         end else begin
            tick();
         end
      end
      req = '0;
      repeat (25) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_q.md
Name: bus_arbiter_q

Overview:
- Synthesizable, parametrised successor to the single-owner transfer bus.
- Buffers per-processor transfer requests in a bounded circular FIFO and grants the bus to one transfer at a time.
- Each granted transfer holds the bus for TRANSFER_TIME cycles, then pulses request_avail at the destination.
- New over the previous generation: bounded queue, per-requester ack/nack when full, source tracking, back-to-back grants, optional round-robin enqueue order.

Parameters:
- NUM_PROC, 4: number of processors (requesters and destinations); must be >= 2.
- TRANSFER_TIME, 100: cycles the bus is held per transfer; must be >= 1.
- QUEUE_DEPTH, 8: FIFO entries; must be >= 1, need not be a power of two.
- Derived, not overridable:
  - ID_W = $clog2(NUM_PROC)
  - CNT_W = $clog2(TRANSFER_TIME+1)
  - Q_W = $clog2(QUEUE_DEPTH+1)

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- request  input  NUM_PROC  per-processor request strobe, sampled each cycle.
- request_dest  input  NUM_PROC x ID_W  destination for each requester.
- request_ack  output  NUM_PROC  registered; high one cycle after a request was enqueued.
- request_nack  output  NUM_PROC  registered; high one cycle after a request was rejected.
- request_avail  output  NUM_PROC  one-cycle pulse at the destination when its transfer completes.
- bus_busy  output  1  high while state is XFER.
- bus_owner  output  ID_W  destination of the current or last transfer.
- bus_src  output  ID_W  source of the current or last transfer.
- queue_count  output  Q_W  current FIFO occupancy.

Behaviour:
- Reset (async assert): FIFO empty (head=tail=count=0), state IDLE, countdown=0. All outputs 0. Queue flushed and any in-flight transfer abandoned; no avail pulse is produced for it. Release takes effect on the first rising edge after deassert.
- FIFO entry = {src, dest}. Circular head/tail pointers wrap at QUEUE_DEPTH-1 -> 0.
- Enqueue, per edge:
  - free = QUEUE_DEPTH - count. A pop on the same edge does not free a slot for that edge's pushes.
  - Asserted requests are scanned in priority order: index 0 upward by default; see the optional feature.
  - The first `free` requests are written in scan order and get request_ack next cycle.
  - The remainder get request_nack next cycle. The requester must re-request; nothing is retained for it.
  - request_dest >= NUM_PROC (possible only when NUM_PROC is not a power of two) is always nacked and never written.
  - ack and nack are never both high for one index.
- FSM:
  - IDLE: if count>0, pop head, latch bus_src/bus_owner, countdown <= TRANSFER_TIME-1, -> XFER. Else stay.
  - XFER: bus_busy=1. If countdown==0, -> DONE. Else countdown--.
  - DONE: request_avail[bus_owner]=1 for this cycle only. If count>0, pop and -> XFER (same load as IDLE). Else -> IDLE.
- Timing:
  - XFER lasts exactly TRANSFER_TIME cycles.
  - Idle bus: request in cycle 0 -> enqueue at edge 1 -> pop at edge 2 -> XFER cycles 2..T+1 -> request_avail in cycle T+2.
  - Back-to-back transfers: period T+1 cycles; no IDLE cycle between them.
- Simultaneous push and pop on one edge: count updates by pushes-minus-1. Pop always reads the entry at head before the edge, so an empty FIFO never pops a same-edge push.
- count never exceeds QUEUE_DEPTH. No overflow or underflow is possible by construction.
- Self-transfer (src==dest) is legal.
- queue_count reflects the registered count.

Optional Feature:
- Macro BUS_ARBITER_RR_EN.
- Defined: enqueue scan starts at (last granted bus_src + 1) mod NUM_PROC and wraps. The pointer resets to start at index 0 and updates on every pop.
- Undefined: fixed scan from index 0, so low indices win when the FIFO is nearly full. Pointer logic is not built.

Test Plan:
- Single transfer: T=4, request[2]=1 dest=1 in cycle 0 -> ack[2] in cycle 1; bus_busy cycles 2-5; request_avail=4'b0010 in cycle 6 only; bus_src=2.
- Back-to-back: T=4, requests 0->3 and 1->2 together in cycle 0 -> avail[3] in cycle 6, avail[2] in cycle 11; bus_busy low only in cycles 6 and 11.
- Full FIFO: DEPTH=2, T=10, all 4 requests in cycle 0 -> ack 4'b0011, nack 4'b1100 in cycle 1; queue_count=2 in cycle 1. With BUS_ARBITER_RR_EN after one grant to src 0, next full-contention cycle favours index 1 upward.
- Push/pop same edge: DEPTH=1, entry pops at edge 2 while a new request is presented in cycle 1 -> new request nacked, since free=0 on that edge.
- Reset mid-transfer: assert rst in cycle 4 of XFER with 2 entries queued -> outputs 0 immediately; no request_avail ever for those entries; queue_count=0.
- Wrap-around: DEPTH=3, 7 sequential single requests, each after the previous avail -> every transfer completes in order with correct src/dest; pointers wrap twice.
